// File: rtl/spi_cmd_receiver_if.sv
// SPI pins plus the command-byte outputs of spi_cmd_receiver, bundled for port
// connection. The slave modport is the receiver's view; master is the controller/consumer.
interface spi_cmd_receiver_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] spi_data;
    logic       spi_flag;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, spi_data, spi_flag, frame_err, overrun
    );

    modport master (
        output sclk, cs_n, mosi,
        input  miso, spi_data, spi_flag, frame_err, overrun
    );
endinterface

// File: rtl/spi_cmd_receiver.sv
// Mode-0 SPI slave that deserializes command bytes into the clk domain, widens each
// completion into a FLAG_CYCLES-long strobe and echoes the last accepted byte on MISO.
module spi_cmd_receiver #(
    parameter int unsigned FLAG_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    spi_cmd_receiver_if.slave  spi_if
);

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        SHIFT      = 2'd2
    } state_t;

    localparam logic [7:0] FLAG_LOAD = 8'(FLAG_CYCLES);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic [7:0] r_echo;
    logic [7:0] r_spi_data;
    logic [7:0] r_flag_cnt;
    logic       r_spi_flag;
    logic       r_err_pend;
    logic       r_frame_err;
    logic       r_overrun;
    logic       r_miso;

    logic [2:0] w_bit_cnt_next;
    logic [7:0] w_rx_next;
    logic [7:0] w_tx_next;
    logic [7:0] w_echo_next;
    logic [7:0] w_data_next;
    logic [7:0] w_flag_cnt_next;
    logic       w_err_pend_next;
    logic       w_overrun_next;
    logic       w_miso_next;

    // cs_n chain resets low so a frame already in progress at reset release is never mistaken for a new one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_if.sclk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_if.cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_if.mosi};
        end
    end

    wire       w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    wire       w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    wire       w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    wire       w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    wire [7:0] w_byte      = {r_rx[6:0], r_mosi_sync[1]};
    wire       w_byte_done = (r_state == SHIFT) && w_sclk_rise && (r_bit_cnt == 3'd7);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_DESEL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_DESEL: if (r_cs_sync[1]) w_state_next = IDLE;  else w_state_next = WAIT_DESEL;
            IDLE:       if (w_cs_fall)    w_state_next = SHIFT; else w_state_next = IDLE;
            SHIFT:      if (w_cs_rise)    w_state_next = IDLE;  else w_state_next = SHIFT;
            default:    w_state_next = WAIT_DESEL;
        endcase
    end

    // Datapath and output decode
    always_comb begin
        w_bit_cnt_next  = r_bit_cnt;
        w_rx_next       = r_rx;
        w_tx_next       = r_tx;
        w_echo_next     = r_echo;
        w_data_next     = r_spi_data;
        w_err_pend_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_bit_cnt_next = 3'd0;
                    w_tx_next      = r_echo;
                end else begin
                    w_tx_next      = r_tx;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_rx_next      = w_byte;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                end else begin
                    w_rx_next      = r_rx;
                end
                // The fall right after a completed byte must not shift, or the new echo MSB is lost
                if (w_byte_done) begin
                    w_data_next = w_byte;
                    w_echo_next = w_byte;
                    w_tx_next   = w_byte;
                end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
                    w_tx_next   = {r_tx[6:0], 1'b0};
                end else begin
                    w_tx_next   = r_tx;
                end
                if (w_cs_rise && (w_bit_cnt_next != 3'd0)) begin
                    w_err_pend_next = 1'b1;
                end else begin
                    w_err_pend_next = 1'b0;
                end
            end
            default: begin
                w_bit_cnt_next = r_bit_cnt;
            end
        endcase

        if (w_byte_done) begin
            w_flag_cnt_next = FLAG_LOAD;
        end else if (r_flag_cnt != 8'd0) begin
            w_flag_cnt_next = r_flag_cnt - 8'd1;
        end else begin
            w_flag_cnt_next = r_flag_cnt;
        end

        w_overrun_next = r_overrun | (w_byte_done & r_spi_flag);

        if (w_state_next == SHIFT) begin
            w_miso_next = w_tx_next[7];
        end else begin
            w_miso_next = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= 3'd0;
            r_rx        <= 8'h00;
            r_tx        <= 8'h00;
            r_echo      <= 8'h00;
            r_spi_data  <= 8'h00;
            r_flag_cnt  <= 8'd0;
            r_spi_flag  <= 1'b0;
            r_err_pend  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_bit_cnt   <= w_bit_cnt_next;
            r_rx        <= w_rx_next;
            r_tx        <= w_tx_next;
            r_echo      <= w_echo_next;
            r_spi_data  <= w_data_next;
            r_flag_cnt  <= w_flag_cnt_next;
            r_spi_flag  <= (r_flag_cnt != 8'd0);
            r_err_pend  <= w_err_pend_next;
            r_frame_err <= r_err_pend;
            r_overrun   <= w_overrun_next;
            r_miso      <= w_miso_next;
        end
    end

    assign spi_if.miso      = r_miso;
    assign spi_if.spi_data  = r_spi_data;
    assign spi_if.spi_flag  = r_spi_flag;
    assign spi_if.frame_err = r_frame_err;
    assign spi_if.overrun   = r_overrun;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Bench for spi_cmd_receiver: directed frame table, multi-cycle corner sequences and
// random frames scored against a byte-level model of the receiver.
module tb_spi_cmd_receiver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_receiver_if bus();
    spi_cmd_receiver_if bus2();

    assign bus.sclk  = sclk;
    assign bus.cs_n  = cs_n;
    assign bus.mosi  = mosi;
    assign bus2.sclk = sclk;
    assign bus2.cs_n = cs_n;
    assign bus2.mosi = mosi;

    spi_cmd_receiver #(.FLAG_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .spi_if(bus.slave)
    );

    // Long-flag instance for the overrun scenario
    spi_cmd_receiver #(.FLAG_CYCLES(64)) dut_ovr (
        .clk(clk), .reset(reset), .spi_if(bus2.slave)
    );

    typedef struct {
        logic [7:0] b;
        int         nbits;
        logic       exp_flag;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [7:0] exp_echo;
    } vec_t;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int cs_rise_cyc = 0;
    logic [7:0] got_q[$];
    int lat_q[$];
    int len_q[$];
    int err_lat_q[$];
    int run_len = 0;
    int err_wide = 0;
    int unstable = 0;
    int ovr_main = 0;
    int rises2 = 0;
    logic prev_flag = 1'b0;
    logic prev_err = 1'b0;
    logic prev_flag2 = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Monitor: records flag pulses, their data, length and latency, plus frame_err pulses
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.spi_flag && !prev_flag) begin
                got_q.push_back(bus.spi_data);
                lat_q.push_back(cyc - last_rise_cyc);
            end
            if (bus.spi_flag) begin
                run_len++;
            end else if (prev_flag) begin
                len_q.push_back(run_len);
                run_len = 0;
            end
            if (bus.spi_flag && prev_flag && bus.spi_data !== prev_data) unstable++;
            if (bus.frame_err) begin
                err_lat_q.push_back(cyc - cs_rise_cyc);
                if (prev_err) err_wide++;
            end
            if (bus.overrun) ovr_main++;
            if (bus2.spi_flag && !prev_flag2) rises2++;
            prev_flag  = bus.spi_flag;
            prev_err   = bus.frame_err;
            prev_data  = bus.spi_data;
            prev_flag2 = bus2.spi_flag;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        got_q.delete();
        lat_q.delete();
        len_q.delete();
        err_lat_q.delete();
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_high();
        wait_cyc(4);
        cs_n = 1'b1;
        cs_rise_cyc = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(4);
    endtask

    // Master side: MSB first, MISO sampled just before each sclk rise
    task automatic send_bits(input logic [7:0] b, input int nbits, input int half, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_cyc(half);
            got = {got[6:0], bus.miso};
            sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_cyc(half);
            sclk = 1'b0;
        end
    endtask

    // Compare everything observed for one completed frame against the model's expectations
    task automatic score_frame(input string tag, input logic [7:0] exp_q[$], input int exp_err, input logic [7:0] exp_data);
        check({tag, "_flag_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_data%0d", tag, k), got_q[k], exp_q[k]);
        for (int k = 0; k < len_q.size(); k++)
            check($sformatf("%s_flag_len%0d", tag, k), len_q[k], 4);
        for (int k = 0; k < lat_q.size(); k++)
            check($sformatf("%s_flag_latency=%0d", tag, lat_q[k]), (lat_q[k] >= 4 && lat_q[k] <= 5), 1);
        check({tag, "_frame_err_count"}, err_lat_q.size(), exp_err);
        for (int k = 0; k < err_lat_q.size(); k++)
            check($sformatf("%s_err_latency=%0d", tag, err_lat_q[k]), (err_lat_q[k] >= 4 && err_lat_q[k] <= 5), 1);
        check({tag, "_spi_data_final"}, bus.spi_data, exp_data);
    endtask

    initial begin
        vec_t vecs[9];
        logic [7:0] g;
        logic [7:0] g2;
        logic [7:0] exp_q[$];
        logic [7:0] echo_m;
        logic [7:0] last_m;
        logic [7:0] rb;
        int nb;
        int half;
        int pbits;

        vecs[0] = '{8'h01, 8, 1'b1, 8'h01, 1'b0, 8'h00};
        vecs[1] = '{8'h02, 8, 1'b1, 8'h02, 1'b0, 8'h01};
        vecs[2] = '{8'hA5, 5, 1'b0, 8'h02, 1'b1, 8'h00};
        vecs[3] = '{8'h01, 8, 1'b1, 8'h01, 1'b0, 8'h02};
        vecs[4] = '{8'hFF, 8, 1'b1, 8'hFF, 1'b0, 8'h01};
        vecs[5] = '{8'h3C, 1, 1'b0, 8'hFF, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 8, 1'b1, 8'h00, 1'b0, 8'hFF};
        vecs[7] = '{8'h80, 7, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[8] = '{8'h5A, 8, 1'b1, 8'h5A, 1'b0, 8'h00};

        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);
        check("reset_spi_data", bus.spi_data, 8'h00);
        check("reset_spi_flag", bus.spi_flag, 1'b0);
        check("reset_miso", bus.miso, 1'b0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        check("reset_overrun", bus.overrun, 1'b0);

        // Single-frame table: full bytes, and partial bytes that must raise frame_err
        for (int i = 0; i < 9; i++) begin
            flush();
            exp_q.delete();
            if (vecs[i].exp_flag) exp_q.push_back(vecs[i].exp_data);
            cs_low();
            send_bits(vecs[i].b, vecs[i].nbits, 4, g);
            cs_high();
            wait_cyc(20);
            score_frame($sformatf("vec%0d", i), exp_q, int'(vecs[i].exp_err), vecs[i].exp_data);
            if (vecs[i].exp_flag) check($sformatf("vec%0d_miso_echo", i), g, vecs[i].exp_echo);
        end

        // Two bytes in one frame; echo starts from the reset value
        do_reset();
        flush();
        cs_low();
        send_bits(8'h02, 8, 4, g);
        wait_cyc(8);
        send_bits(8'hA5, 8, 4, g2);
        cs_high();
        wait_cyc(20);
        exp_q = '{8'h02, 8'hA5};
        score_frame("two_byte", exp_q, 0, 8'hA5);
        check("two_byte_miso1", g, 8'h00);
        check("two_byte_miso2", g2, 8'h02);

        // cs_n rise coincides with the 8th sclk rise: byte accepted, no frame_err
        flush();
        cs_low();
        send_bits(8'hC3, 7, 4, g);
        mosi = 1'b1;
        wait_cyc(4);
        sclk = 1'b1;
        cs_n = 1'b1;
        last_rise_cyc = cyc;
        cs_rise_cyc = cyc;
        wait_cyc(4);
        sclk = 1'b0;
        wait_cyc(20);
        exp_q = '{8'hC3};
        score_frame("simul_cs_sclk", exp_q, 0, 8'hC3);

        // Reset after 3 bits with cs_n low, then the rest of the byte is ignored
        flush();
        cs_low();
        send_bits(8'hE0, 3, 4, g);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        check("midreset_spi_data", bus.spi_data, 8'h00);
        check("midreset_spi_flag", bus.spi_flag, 1'b0);
        check("midreset_overrun", bus.overrun, 1'b0);
        check("midreset_miso", bus.miso, 1'b0);
        send_bits(8'hFF, 5, 4, g);
        check("midreset_miso_during_bits", g, 8'h00);
        cs_high();
        wait_cyc(20);
        exp_q.delete();
        score_frame("midreset_tail", exp_q, 0, 8'h00);
        flush();
        cs_low();
        send_bits(8'h02, 8, 4, g);
        cs_high();
        wait_cyc(20);
        exp_q = '{8'h02};
        score_frame("after_midreset", exp_q, 0, 8'h02);
        check("after_midreset_miso", g, 8'h00);

        // Idle noise with cs_n high
        flush();
        for (int i = 0; i < 3; i++) begin
            send_bits(8'($urandom), 8, 3, g);
            check($sformatf("idle_noise_miso%0d", i), g, 8'h00);
        end
        wait_cyc(20);
        exp_q.delete();
        score_frame("idle_noise", exp_q, 0, 8'h02);

        // Back-to-back bytes at fastest legal sclk into the 64-cycle flag instance
        do_reset();
        rises2 = 0;
        check("ovr_reset_overrun", bus2.overrun, 1'b0);
        cs_low();
        send_bits(8'h01, 8, 3, g);
        send_bits(8'h02, 8, 3, g);
        wait_cyc(6);
        check("ovr_flag_high", bus2.spi_flag, 1'b1);
        check("ovr_data", bus2.spi_data, 8'h02);
        check("ovr_overrun_set", bus2.overrun, 1'b1);
        cs_high();
        wait_cyc(100);
        check("ovr_single_flag_edge", rises2, 1);
        check("ovr_flag_done", bus2.spi_flag, 1'b0);
        check("ovr_overrun_sticky", bus2.overrun, 1'b1);
        do_reset();
        check("ovr_cleared_by_reset", bus2.overrun, 1'b0);

        // Random frames against the byte-level model
        echo_m = 8'h00;
        last_m = 8'h00;
        for (int f = 0; f < 25; f++) begin
            flush();
            exp_q.delete();
            nb = $urandom_range(1, 3);
            half = $urandom_range(3, 6);
            pbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            cs_low();
            for (int j = 0; j < nb; j++) begin
                rb = 8'($urandom);
                send_bits(rb, 8, half, g);
                check($sformatf("rnd%0d_miso%0d", f, j), g, echo_m);
                echo_m = rb;
                last_m = rb;
                exp_q.push_back(rb);
                wait_cyc($urandom_range(0, 10));
            end
            if (pbits != 0) send_bits(8'($urandom), pbits, half, g);
            cs_high();
            wait_cyc(20);
            score_frame($sformatf("rnd%0d", f), exp_q, (pbits != 0) ? 1 : 0, last_m);
        end

        check("flag_data_stable", unstable, 0);
        check("frame_err_width", err_wide, 0);
        check("main_overrun_never", ovr_main, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
